// File: rtl/fetch.sv
// Instruction fetch stage of the swt16 pipeline: owns the PC, issues synchronous
// program-memory reads, and registers returned words (tagged for two-word instructions) into decode.
module fetch #(
  parameter int unsigned                  PMEM_ADDR_WIDTH = 12,
  parameter int unsigned                  PMEM_WORD_WIDTH = 16,
  parameter int unsigned                  PC_WIDTH        = 12,
  parameter int unsigned                  OPCODE_WIDTH    = 4,
  parameter logic [OPCODE_WIDTH-1:0]      LONG_OPCODE     = 4'hF,
  parameter logic [PC_WIDTH-1:0]          RESET_PC        = '0,
  parameter logic [PMEM_WORD_WIDTH-1:0]   NOP_WORD        = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_set_pc,
  input  logic [PC_WIDTH-1:0]         in_new_pc,
  input  logic                        in_flush,
  input  logic                        in_stall,
  output logic [PMEM_ADDR_WIDTH-1:0]  out_pmem_addr,
  input  logic [PMEM_WORD_WIDTH-1:0]  in_pmem_data,
  output logic [PMEM_WORD_WIDTH-1:0]  out_instr,
  output logic [PC_WIDTH-1:0]         out_pc,
  output logic                        out_instr_valid,
  output logic                        out_second_word
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  typedef enum logic {FIRST, SECOND} state_e;

  state_e                       state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q;
  logic [PC_WIDTH-1:0]          req_pc;
  logic                         req_valid;
  logic                         skid_valid;
  logic                         skid_second;
  logic [PMEM_WORD_WIDTH-1:0]   skid_instr;
  logic [PC_WIDTH-1:0]          skid_pc;

  logic                         redirect;
  logic                         issue;
  logic                         live;
  logic                         live_second;
  logic                         load_valid;
  logic                         load_second;
  logic [PMEM_WORD_WIDTH-1:0]   load_instr;
  logic [PC_WIDTH-1:0]          load_pc;

  assign redirect      = in_set_pc || in_flush;
  assign issue         = !in_stall && !in_set_pc;
  assign live          = req_valid && !redirect;
  assign live_second   = (state_q == SECOND);
  assign out_pmem_addr = pc_q[PMEM_ADDR_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else begin
      req_valid <= issue;
      if (issue) begin
        req_pc <= pc_q;
        pc_q   <= pc_q + PC_ONE;
      end else if (in_set_pc) begin
        pc_q <= in_new_pc;
      end
    end
  end

  // The skid word always drains before the pipe can return anything new, so it wins the select.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_valid  = 1'b0;
    load_second = 1'b0;
    load_instr  = NOP_WORD;
    load_pc     = req_pc;
    if (!redirect) begin
      if (skid_valid) begin
        load_valid  = 1'b1;
        load_second = skid_second;
        load_instr  = skid_instr;
        load_pc     = skid_pc;
      end else if (live) begin
        load_valid  = 1'b1;
        load_second = live_second;
        load_instr  = in_pmem_data;
        load_pc     = req_pc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FIRST;
    end else if (!in_stall && load_valid) begin
      if (!load_second && (load_instr[PMEM_WORD_WIDTH-1 -: OPCODE_WIDTH] == LONG_OPCODE)) begin
        state_d = SECOND;
      end else begin
        state_d = FIRST;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush forces a bubble into decode even while decode is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_instr       <= NOP_WORD;
      out_pc          <= '0;
      out_instr_valid <= 1'b0;
      out_second_word <= 1'b0;
    end else if (in_flush || !in_stall) begin
      out_instr       <= load_instr;
      out_pc          <= load_pc;
      out_instr_valid <= load_valid;
      out_second_word <= load_valid && load_second;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      skid_valid <= 1'b0;
    end else if (redirect || !in_stall) begin
      skid_valid <= 1'b0;
    end else if (live) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid payload is qualified by skid_valid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (!redirect && in_stall && live) begin
      skid_instr  <= in_pmem_data;
      skid_pc     <= req_pc;
      skid_second <= live_second;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a queue-based model of in-order delivery checked every cycle,
// plus directed literal expectations for streaming, stall, redirect, two-word tags, wrap and reset.
module tb_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_set_pc = 1'b0;
  logic [11:0] in_new_pc = '0;
  logic        in_flush = 1'b0;
  logic        in_stall = 1'b0;
  logic [11:0] out_pmem_addr;
  logic [15:0] in_pmem_data;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic        out_instr_valid;
  logic        out_second_word;

  logic [11:0] wrap_addr;
  logic [15:0] wrap_data;
  logic [15:0] wrap_instr;
  logic [11:0] wrap_pc;
  logic        wrap_valid;
  logic        wrap_second;

  logic [15:0] pmem [4096];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch u_dut (
    .clock(clock), .reset(reset), .in_set_pc(in_set_pc), .in_new_pc(in_new_pc),
    .in_flush(in_flush), .in_stall(in_stall), .out_pmem_addr(out_pmem_addr),
    .in_pmem_data(in_pmem_data), .out_instr(out_instr), .out_pc(out_pc),
    .out_instr_valid(out_instr_valid), .out_second_word(out_second_word)
  );

  fetch #(.RESET_PC(12'hFFE)) u_wrap (
    .clock(clock), .reset(reset), .in_set_pc(1'b0), .in_new_pc(12'h000),
    .in_flush(1'b0), .in_stall(1'b0), .out_pmem_addr(wrap_addr),
    .in_pmem_data(wrap_data), .out_instr(wrap_instr), .out_pc(wrap_pc),
    .out_instr_valid(wrap_valid), .out_second_word(wrap_second)
  );

  // Synchronous-read program memory, one cycle of latency.
  always @(posedge clock) begin
    in_pmem_data <= pmem[out_pmem_addr];
    wrap_data    <= pmem[wrap_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model: requested addresses queue up in program order; a request made in one cycle may be
  // delivered from the next edge on, redirects drop everything queued, and a stalled decode
  // simply leaves words waiting. The immediate tag follows the program-order word sequence.
  bit          model_live = 1'b0;
  logic [11:0] m_next_pc;
  logic [11:0] waiting [$];
  bit          m_expect_imm;
  logic [15:0] m_instr;
  logic [11:0] m_pc_out;
  bit          m_valid;
  bit          m_second;

  always @(posedge clock) begin
    if (reset) begin
      model_live   = 1'b1;
      m_next_pc    = 12'h000;
      waiting.delete();
      m_expect_imm = 1'b0;
      m_instr      = 16'h0000;
      m_pc_out     = 12'h000;
      m_valid      = 1'b0;
      m_second     = 1'b0;
    end else if (model_live) begin
      if (in_set_pc || in_flush) begin
        waiting.delete();
        m_expect_imm = 1'b0;
      end
      if (in_flush || !in_stall) begin
        if (waiting.size() > 0) begin
          m_pc_out     = waiting.pop_front();
          m_instr      = pmem[m_pc_out];
          m_valid      = 1'b1;
          m_second     = m_expect_imm;
          m_expect_imm = !m_second && (m_instr[15:12] == 4'hF);
        end else begin
          m_instr  = 16'h0000;
          m_valid  = 1'b0;
          m_second = 1'b0;
        end
      end
      if (!in_stall && !in_set_pc) begin
        waiting.push_back(m_next_pc);
        m_next_pc = m_next_pc + 12'h001;
      end else if (in_set_pc) begin
        m_next_pc = in_new_pc;
      end
    end
  end

  always @(negedge clock) begin
    if (model_live) begin
      check("model_valid", {31'b0, out_instr_valid}, {31'b0, m_valid});
      check("model_instr", {16'b0, out_instr}, {16'b0, m_instr});
      check("model_second", {31'b0, out_second_word}, {31'b0, m_second});
      check("model_addr", {20'b0, out_pmem_addr}, {20'b0, m_next_pc});
      if (m_valid) check("model_pc", {20'b0, out_pc}, {20'b0, m_pc_out});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

  logic [11:0] wrap_exp_pc   [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
  logic [15:0] wrap_exp_instr[4] = '{16'h1FFE, 16'h1FFF, 16'h1000, 16'h1001};
  logic [11:0] wrap_exp_addr [4] = '{12'h000, 12'h001, 12'h002, 12'h003};
  logic        tag_exp       [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    for (int k = 0; k < 4096; k++) pmem[k] = 16'h1000 + 16'(k);

    // Reset state
    step();
    step();
    @(negedge clock);
    check("rst_valid", {31'b0, out_instr_valid}, 32'h0);
    check("rst_instr", {16'b0, out_instr}, 32'h0000);
    check("rst_pc", {20'b0, out_pc}, 32'h000);
    check("rst_addr", {20'b0, out_pmem_addr}, 32'h000);
    check("wrap_rst_addr", {20'b0, wrap_addr}, 32'hFFE);

    // Streaming from reset; wrap instance runs alongside from 0xFFE
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clock);
      check("stream_pc", {20'b0, out_pc}, 32'(k));
      check("stream_instr", {16'b0, out_instr}, 32'h1000 + 32'(k));
      check("stream_valid", {31'b0, out_instr_valid}, 32'h1);
      check("wrap_pc", {20'b0, wrap_pc}, {20'b0, wrap_exp_pc[k]});
      check("wrap_instr", {16'b0, wrap_instr}, {16'b0, wrap_exp_instr[k]});
      check("wrap_addr", {20'b0, wrap_addr}, {20'b0, wrap_exp_addr[k]});
    end

    // Stall three cycles while out_pc=5
    step();
    step();
    @(negedge clock);
    check("pre_stall_pc", {20'b0, out_pc}, 32'h005);
    in_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clock);
      check("stall_hold_pc", {20'b0, out_pc}, 32'h005);
      check("stall_hold_valid", {31'b0, out_instr_valid}, 32'h1);
    end
    in_stall = 1'b0;
    for (int k = 6; k < 9; k++) begin
      step();
      @(negedge clock);
      check("release_pc", {20'b0, out_pc}, 32'(k));
      check("release_instr", {16'b0, out_instr}, 32'h1000 + 32'(k));
    end

    // Redirect with flush to 0x040
    in_set_pc = 1'b1;
    in_flush  = 1'b1;
    in_new_pc = 12'h040;
    step();
    in_set_pc = 1'b0;
    in_flush  = 1'b0;
    @(negedge clock);
    check("redir_bubble1", {31'b0, out_instr_valid}, 32'h0);
    step();
    @(negedge clock);
    check("redir_bubble2", {31'b0, out_instr_valid}, 32'h0);
    step();
    @(negedge clock);
    check("redir_pc", {20'b0, out_pc}, 32'h040);
    check("redir_instr", {16'b0, out_instr}, 32'h1040);
    check("redir_valid", {31'b0, out_instr_valid}, 32'h1);
    step();
    @(negedge clock);
    check("redir_next_pc", {20'b0, out_pc}, 32'h041);

    // Two-word instruction tagging
    reset   = 1'b1;
    pmem[0] = 16'hF123;
    pmem[1] = 16'hF0FF;
    pmem[2] = 16'h2000;
    step();
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clock);
      check("tag_pc", {20'b0, out_pc}, 32'(k));
      check("tag_second", {31'b0, out_second_word}, {31'b0, tag_exp[k]});
    end

    // Flush while stalled with the skid holding pc 3
    in_stall = 1'b1;
    step();
    @(negedge clock);
    check("skid_hold_pc", {20'b0, out_pc}, 32'h002);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    @(negedge clock);
    check("flush_stall_valid", {31'b0, out_instr_valid}, 32'h0);
    check("flush_stall_instr", {16'b0, out_instr}, 32'h0000);
    check("flush_stall_second", {31'b0, out_second_word}, 32'h0);
    step();
    in_stall = 1'b0;
    step();
    @(negedge clock);
    check("flush_release_bubble", {31'b0, out_instr_valid}, 32'h0);
    step();
    @(negedge clock);
    check("flush_resume_pc", {20'b0, out_pc}, 32'h004);
    check("flush_resume_instr", {16'b0, out_instr}, 32'h1004);

    // Reset in the middle of a stall
    in_stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    @(negedge clock);
    check("midrst_valid", {31'b0, out_instr_valid}, 32'h0);
    check("midrst_instr", {16'b0, out_instr}, 32'h0000);
    check("midrst_pc", {20'b0, out_pc}, 32'h000);
    check("midrst_second", {31'b0, out_second_word}, 32'h0);
    check("midrst_addr", {20'b0, out_pmem_addr}, 32'h000);
    reset    = 1'b0;
    in_stall = 1'b0;
    step();
    step();
    @(negedge clock);
    check("restart_pc", {20'b0, out_pc}, 32'h000);
    check("restart_instr", {16'b0, out_instr}, 32'hF123);
    check("restart_valid", {31'b0, out_instr_valid}, 32'h1);
    step();
    @(negedge clock);
    check("restart_second", {31'b0, out_second_word}, 32'h1);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
